// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the memory arbiter: access types, arbiter states and IO select.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ACC_NONE = 2'b00,
    ACC_BYTE = 2'b01,
    ACC_HALF = 2'b10,
    ACC_WORD = 2'b11
  } accessTypeT;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    INST   = 2'b01,
    DREAD  = 2'b10,
    DWRITE = 2'b11
  } arbStateT;

  localparam logic [1:0] IO_SEL_VALUE = 2'b11;
  localparam logic [1:0] FETCH_LAST   = 2'd3;

  // Index of the final byte of an access (byte 0, half 1, word 3).
  function automatic logic [1:0] lastIndex(input logic [1:0] accType);
    case (accessTypeT'(accType))
      ACC_BYTE: lastIndex = 2'd0;
      ACC_HALF: lastIndex = 2'd1;
      default:  lastIndex = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_engine.sv
// Byte sequencer for the memory arbiter: walks addr+0..addr+N-1 over the 8-bit RAM port,
// shifting store bytes out and assembling load bytes that return one cycle after their address.
module mem_byte_engine
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_SEL_HI  = 17
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic                  startEn,
  input  logic                  startRead,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  input  logic [31:0]           startData,
  input  logic [1:0]            startLast,
  input  logic                  abort,
  input  logic                  ioBufferFull,
  input  logic [7:0]            memIn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [7:0]            memOut,
  output logic                  memWrite,
  output logic                  rdDone,
  output logic                  wrDone,
  output logic [31:0]           rdWord
);

  logic                  active;
  logic                  isRead;
  logic [1:0]            cnt;
  logic [1:0]            lastIdx;
  logic [ADDR_WIDTH-1:0] baseAddr;
  logic [31:0]           wrData;
  logic                  capValid;
  logic [1:0]            capIdx;
  logic [31:0]           asmWord;
  logic [ADDR_WIDTH-1:0] byteAddr;
  logic                  stall;
  logic                  step;

  // Offset addition wraps naturally at ADDR_WIDTH bits.
  assign byteAddr = baseAddr + ADDR_WIDTH'(cnt);
  assign stall    = active & ~isRead & ioBufferFull & (byteAddr[IO_SEL_HI -: 2] == IO_SEL_VALUE);
  assign step     = active & ~stall;
  assign memAddr  = step ? byteAddr : '0;
  assign memWrite = step & ~isRead;
  assign memOut   = memWrite ? wrData[{cnt, 3'b000} +: 8] : 8'h00;
  assign wrDone   = memWrite & (cnt == lastIdx);
  assign rdDone   = capValid & (capIdx == lastIdx);

  always_comb begin
    rdWord = asmWord;
    if (capValid) rdWord[{capIdx, 3'b000} +: 8] = memIn;
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      active   <= 1'b0;
      isRead   <= 1'b0;
      cnt      <= 2'd0;
      lastIdx  <= 2'd0;
      baseAddr <= '0;
      wrData   <= 32'h0;
      capValid <= 1'b0;
      capIdx   <= 2'd0;
      asmWord  <= 32'h0;
    end else begin
      capValid <= active & isRead & ~abort;
      capIdx   <= cnt;
      if (capValid) asmWord[{capIdx, 3'b000} +: 8] <= memIn;
      if (abort) begin
        active <= 1'b0;
        cnt    <= 2'd0;
      end else if (startEn) begin
        active   <= 1'b1;
        isRead   <= startRead;
        cnt      <= 2'd0;
        lastIdx  <= startLast;
        baseAddr <= startAddr;
        wrData   <= startData;
        asmWord  <= 32'h0;
      end else if (step) begin
        if (cnt == lastIdx) begin
          active <= 1'b0;
          cnt    <= 2'd0;
        end else begin
          cnt <= cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one byte-wide RAM port.
// Build option MEMORY_ARBITER_ROUND_ROBIN_EN: after a data completion a waiting fetch goes first.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_SEL_HI  = 17
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic                  clearIn,
  input  logic                  instReq,
  input  logic [ADDR_WIDTH-1:0] instAddr,
  output logic                  instValid,
  output logic [31:0]           instData,
  input  logic [1:0]            accessType,
  input  logic                  readWriteIn,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic [31:0]           dataIn,
  output logic                  dataValid,
  output logic [31:0]           dataOut,
  output logic                  dataWriteSuc,
  input  logic [7:0]            memIn,
  output logic [7:0]            memOut,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memWrite,
  input  logic                  ioBufferFull
);

  arbStateT              state;
  logic                  pendValid;
  logic                  pendRead;
  logic [1:0]            pendType;
  logic [ADDR_WIDTH-1:0] pendAddr;
  logic [31:0]           pendData;
  logic                  newReq;
  logic                  effValid;
  logic                  effRead;
  logic [1:0]            effType;
  logic [ADDR_WIDTH-1:0] effAddr;
  logic [31:0]           effData;
  logic                  instWins;
  logic                  grantInst;
  logic                  grantData;
  logic                  startEn;
  logic                  abort;
  logic                  rdDone;
  logic                  wrDone;
  logic [31:0]           rdWord;

  // A request arriving this cycle can be granted at once, so the slot is bypassed.
  assign newReq   = (accessType != ACC_NONE);
  assign effRead  = pendValid ? pendRead : readWriteIn;
  assign effType  = pendValid ? pendType : accessType;
  assign effAddr  = pendValid ? pendAddr : dataAddr;
  assign effData  = pendValid ? pendData : dataIn;
  assign effValid = (pendValid | newReq) & ~(clearIn & effRead);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic lastWasData;
  assign instWins = instReq & (~effValid | lastWasData);

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) lastWasData <= 1'b0;
    else if (startEn) lastWasData <= 1'b0;
    else if ((state == DREAD && rdDone && !clearIn) || (state == DWRITE && wrDone))
      lastWasData <= 1'b1;
  end
`else
  assign instWins = instReq & ~effValid;
`endif

  assign grantInst = (state == IDLE) & instWins;
  assign grantData = (state == IDLE) & effValid & ~instWins;
  assign startEn   = grantInst | grantData;
  assign abort     = clearIn & ((state == INST) | (state == DREAD));

  mem_byte_engine #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .IO_SEL_HI (IO_SEL_HI)
  ) byteEngine (
    .clockIn     (clockIn),
    .resetIn     (resetIn),
    .startEn     (startEn),
    .startRead   (grantInst | effRead),
    .startAddr   (grantInst ? instAddr : effAddr),
    .startData   (effData),
    .startLast   (grantInst ? FETCH_LAST : lastIndex(effType)),
    .abort       (abort),
    .ioBufferFull(ioBufferFull),
    .memIn       (memIn),
    .memAddr     (memAddr),
    .memOut      (memOut),
    .memWrite    (memWrite),
    .rdDone      (rdDone),
    .wrDone      (wrDone),
    .rdWord      (rdWord)
  );

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state        <= IDLE;
      instValid    <= 1'b0;
      instData     <= 32'h0;
      dataValid    <= 1'b0;
      dataOut      <= 32'h0;
      dataWriteSuc <= 1'b0;
      pendValid    <= 1'b0;
      pendRead     <= 1'b0;
      pendType     <= 2'b00;
      pendAddr     <= '0;
      pendData     <= 32'h0;
    end else begin
      instValid    <= 1'b0;
      dataValid    <= 1'b0;
      dataWriteSuc <= 1'b0;
      case (state)
        IDLE: begin
          if (grantInst) state <= INST;
          else if (grantData) state <= effRead ? DREAD : DWRITE;
        end
        INST: begin
          if (clearIn) state <= IDLE;
          else if (rdDone) begin
            instValid <= 1'b1;
            instData  <= rdWord;
            state     <= IDLE;
          end
        end
        DREAD: begin
          if (clearIn) state <= IDLE;
          else if (rdDone) begin
            dataValid <= 1'b1;
            dataOut   <= rdWord;
            state     <= IDLE;
          end
        end
        DWRITE: begin
          if (wrDone) begin
            dataWriteSuc <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Writes survive a flush; reads waiting in the slot are dropped.
      if (grantData) pendValid <= 1'b0;
      else if (newReq) begin
        pendValid <= ~(clearIn & readWriteIn);
        pendRead  <= readWriteIn;
        pendType  <= accessType;
        pendAddr  <= dataAddr;
        pendData  <= dataIn;
      end else if (clearIn & pendRead) pendValid <= 1'b0;
    end
  end

endmodule
